mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I$ and D$.
// One transaction at a time, with a watchdog abort and a release cycle.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_read_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_ready_o,
  input  logic              r1_read_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [1:0]        grant_o,
  output logic              timeout_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RELEASE
  } state_e;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [9:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                terr_q, terr_d;

  logic req0, req1, pick1, serving;

  assign req0    = r0_read_i | r0_write_i;
  assign req1    = r1_read_i | r1_write_i;
  // On a tie, the requester not served last wins.
  assign pick1   = req1 & (~req0 | ~last_q);
  assign serving = (state_q == SERVE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          wr_d    = pick1 ? r1_write_i : r0_write_i;
          rd_d    = ~wr_d;
          addr_d  = pick1 ? r1_addr_i : r0_addr_i;
          wdata_d = pick1 ? r1_wdata_i : r0_wdata_i;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (mem_ready_i || cnt_q == CNT_LAST) begin
          last_d  = grant_q[1];
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          grant_d = 2'b00;
          state_d = RELEASE;
          if (!mem_ready_i) terr_d = 1'b1;
        end else if (cnt_q != 10'h3FF) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  assign r0_ready_o    = serving & mem_ready_i & grant_q[0];
  assign r1_ready_o    = serving & mem_ready_i & grant_q[1];
  assign rdata_o       = mem_rdata_i;
  assign mem_read_o    = rd_q;
  assign mem_write_o   = wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign grant_o       = grant_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model compared every
// cycle, plus literal expectations per scenario.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ready, r1_ready;
  logic [DW-1:0] rdata, mem_rdata, mem_wdata;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant;
  logic          timeout_err;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_read_i(r0_read), .r0_write_i(r0_write),
    .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r0_ready_o(r0_ready),
    .r1_read_i(r1_read), .r1_write_i(r1_write),
    .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r1_ready_o(r1_ready),
    .rdata_o(rdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .grant_o(grant), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 serving owner, 2 release.
  int            m_ph = 0;
  int            m_own = 0;
  int            m_age = 0;
  int            m_last = 1;
  bit            m_ok = 0;
  bit            m_rd = 0, m_wr = 0, m_terr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_own = 0; m_age = 0; m_last = 1;
      m_rd = 0; m_wr = 0; m_terr = 0;
      m_addr = '0; m_wdata = '0; m_ok = 1;
    end else begin
      case (m_ph)
        0: begin
          bit q0, q1;
          q0 = r0_read | r0_write;
          q1 = r1_read | r1_write;
          if (q0 || q1) begin
            if (q0 && q1) m_own = 1 - m_last;
            else m_own = q1 ? 1 : 0;
            m_wr    = m_own ? r1_write : r0_write;
            m_rd    = !m_wr;
            m_addr  = m_own ? r1_addr : r0_addr;
            m_wdata = m_own ? r1_wdata : r0_wdata;
            m_age   = 0;
            m_ph    = 1;
          end
        end
        1: begin
          if (mem_ready || m_age == TO - 1) begin
            if (!mem_ready) m_terr = 1;
            m_last = m_own;
            m_rd = 0; m_wr = 0;
            m_ph = 2;
          end else begin
            m_age++;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  int  rd_hi = 0, rd_rise = 0, p0 = 0, p1 = 0;
  bit  prev_rd = 0;

  always @(negedge clk) begin
    #2;
    if (m_ok) begin
      logic [1:0] eg;
      eg = (m_ph == 1) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      chk("grant", grant, eg);
      chk("mem_read", mem_read, m_rd);
      chk("mem_write", mem_write, m_wr);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("timeout_err", timeout_err, m_terr);
      chk("r0_ready", r0_ready,
          (m_ph == 1 && m_own == 0 && mem_ready));
      chk("r1_ready", r1_ready,
          (m_ph == 1 && m_own == 1 && mem_ready));
      chk("rdata", rdata, mem_rdata);
      chk("onehot", $countones(grant) <= 1, 1'b1);
    end
    if (mem_read) rd_hi++;
    if (mem_read && !prev_rd) rd_rise++;
    prev_rd = mem_read;
    if (r0_ready) p0++;
    if (r1_ready) p1++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rd_hi = 0; rd_rise = 0; p0 = 0; p1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    r0_read = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
    r1_read = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_rd", mem_read, 1'b0);
    chk("rst_wr", mem_write, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_terr", timeout_err, 1'b0);
    rst_n = 1;
    tick();

    // single read
    clr();
    r1_read = 1; r1_addr = 10'h2A4;
    tick();
    chk("t1_grant", grant, 2'b10);
    chk("t1_addr", mem_addr, 10'h2A4);
    tick(); tick(); tick();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF; r1_read = 0;
    #1;
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_ready", r1_ready, 1'b1);
    tick();
    mem_ready = 0;
    chk("t1_rd_drop", mem_read, 1'b0);
    tick();
    chk("t1_rd_cycles", rd_hi, 4);
    chk("t1_p1", p1, 1);
    chk("t1_p0", p0, 0);

    // tie after reset
    clr();
    r0_read = 1; r0_addr = 10'h011;
    r1_write = 1; r1_addr = 10'h155; r1_wdata = 32'hCAFEF00D;
    tick();
    chk("t2_g0", grant, 2'b01);
    chk("t2_rd", mem_read, 1'b1);
    chk("t2_a0", mem_addr, 10'h011);
    mem_ready = 1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ready = 0;
    chk("t2_rel", grant, 2'b00);
    tick();
    tick();
    chk("t2_g1", grant, 2'b10);
    chk("t2_wr", mem_write, 1'b1);
    chk("t2_wd", mem_wdata, 32'hCAFEF00D);
    chk("t2_a1", mem_addr, 10'h155);
    mem_ready = 1; r0_read = 0; r1_write = 0;
    tick();
    mem_ready = 0;
    tick();
    chk("t2_p0", p0, 1);
    chk("t2_p1", p1, 1);

    // stale request absorbed by release
    clr();
    r0_read = 1; r0_addr = 10'h077;
    tick();
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();
    r0_read = 0;
    tick(); tick();
    chk("t3_rise", rd_rise, 1);
    chk("t3_hi", rd_hi, 1);
    chk("t3_p0", p0, 1);

    // read+write together
    clr();
    r1_read = 1; r1_write = 1;
    r1_addr = 10'h3FF; r1_wdata = 32'h12345678;
    tick();
    chk("t4_wr", mem_write, 1'b1);
    chk("t4_rd", mem_read, 1'b0);
    chk("t4_wd", mem_wdata, 32'h12345678);
    mem_ready = 1; r1_read = 0; r1_write = 0;
    tick();
    mem_ready = 0;
    tick();

    // watchdog abort
    clr();
    r0_read = 1; r0_addr = 10'h0AA;
    tick();
    r0_read = 0;
    tick(); tick(); tick();
    chk("t5_rd_s4", mem_read, 1'b1);
    chk("t5_terr0", timeout_err, 1'b0);
    tick();
    chk("t5_rd_drop", mem_read, 1'b0);
    chk("t5_terr1", timeout_err, 1'b1);
    tick();
    chk("t5_hi", rd_hi, 4);
    chk("t5_p0", p0, 0);
    r1_read = 1; r1_addr = 10'h100;
    tick();
    r1_read = 0; mem_ready = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_ready = 0;
    tick();
    chk("t5_p1", p1, 1);
    chk("t5_sticky", timeout_err, 1'b1);

    // continuous contention alternates
    clr();
    r0_read = 1; r0_addr = 10'h001;
    r1_read = 1; r1_addr = 10'h002;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_alt", grant, (i % 2) ? 2'b10 : 2'b01);
      mem_ready = 1;
      tick();
      mem_ready = 0;
      if (i == 3) begin
        r0_read = 0; r1_read = 0;
      end
      tick();
    end
    chk("t6_p0", p0, 2);
    chk("t6_p1", p1, 2);

    // reset mid-serve
    clr();
    r1_read = 1; r1_addr = 10'h222;
    tick();
    r1_read = 0;
    tick();
    chk("t7_busy", mem_read, 1'b1);
    rst_n = 0;
    tick();
    rst_n = 1; mem_ready = 1; mem_rdata = 32'h0000BEEF;
    #1;
    chk("t7_grant", grant, 2'b00);
    chk("t7_rd", mem_read, 1'b0);
    chk("t7_addr", mem_addr, 0);
    chk("t7_wd", mem_wdata, 0);
    chk("t7_terr", timeout_err, 1'b0);
    chk("t7_r1rdy", r1_ready, 1'b0);
    tick();
    mem_ready = 0;
    tick();
    chk("t7_p1", p1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
